// File: rtl/iir_biquad_lpf.sv
// Direct-form-I biquad low-pass filter with valid/ack handshakes.
// A single time-shared multiplier accumulates five product terms per sample.
module iir_biquad_lpf #(
   parameter int                    DW   = 32,
   parameter int                    CW   = 18,
   parameter int                    FRAC = 16,
   parameter logic signed [CW-1:0]  B0   = CW'(65536),
   parameter logic signed [CW-1:0]  B1   = '0,
   parameter logic signed [CW-1:0]  B2   = '0,
   parameter logic signed [CW-1:0]  A1   = '0,
   parameter logic signed [CW-1:0]  A2   = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        input_a,
   input  logic                 input_a_stb,
   output logic                 input_a_ack,
   output logic [DW-1:0]        output_z,
   output logic                 output_z_stb,
   input  logic                 output_z_ack,
   output logic                 sat_flag
);

   localparam int AW = DW + CW + 3;
   localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = ~MAXV;
   localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FRAC-1);

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                  state;
   logic [2:0]              term;
   logic signed [DW-1:0]    x0, x1, x2, y1, y2;
   logic signed [AW-1:0]    acc;

   logic signed [DW-1:0]    mul_x;
   logic signed [CW-1:0]    mul_c;
   logic                    mul_sub;
   logic signed [DW+CW-1:0] prod;
   logic signed [AW-1:0]    prod_ext;
   logic signed [AW-1:0]    rnd;
   logic signed [AW-1:0]    shifted;
   logic signed [DW-1:0]    sat_val;
   logic                    clip;

   assign input_a_ack = (state == IDLE) && !rst;

   // Operand select: feedback terms are subtracted rather than negating the coefficient.
   always_comb begin
      mul_x   = x0;
      mul_c   = B0;
      mul_sub = 1'b0;
      case (term)
         3'd0: begin mul_x = x0; mul_c = B0; end
         3'd1: begin mul_x = x1; mul_c = B1; end
         3'd2: begin mul_x = x2; mul_c = B2; end
         3'd3: begin mul_x = y1; mul_c = A1; mul_sub = 1'b1; end
         default: begin mul_x = y2; mul_c = A2; mul_sub = 1'b1; end
      endcase
   end

   assign prod     = mul_x * mul_c;
   assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
   assign rnd      = acc + HALF;
   assign shifted  = rnd >>> FRAC;

   always_comb begin
      clip    = 1'b0;
      sat_val = shifted[DW-1:0];
      if (shifted > MAXV) begin
         clip    = 1'b1;
         sat_val = MAXV[DW-1:0];
      end else if (shifted < MINV) begin
         clip    = 1'b1;
         sat_val = MINV[DW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         term         <= '0;
         acc          <= '0;
         x0           <= '0;
         x1           <= '0;
         x2           <= '0;
         y1           <= '0;
         y2           <= '0;
         output_z     <= '0;
         output_z_stb <= 1'b0;
         sat_flag     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (input_a_stb) begin
                  x0    <= input_a;
                  acc   <= '0;
                  term  <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc  <= mul_sub ? acc - prod_ext : acc + prod_ext;
               term <= term + 3'd1;
               if (term == 3'd4) state <= ROUND;
            end
            ROUND: begin
               output_z     <= sat_val;
               output_z_stb <= 1'b1;
               sat_flag     <= sat_flag | clip;
               x2           <= x1;
               x1           <= x0;
               y2           <= y1;
               y1           <= sat_val;
               state        <= OUT;
            end
            OUT: begin
               if (output_z_ack) begin
                  output_z_stb <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_biquad_lpf.sv
// Directed bench for iir_biquad_lpf: four instances with different coefficient
// sets share clock and reset; expected outputs are hand-computed constants.
module tb_iir_biquad_lpf;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [31:0] in_a  [4];
   logic               stb   [4];
   logic               ack   [4];
   logic signed [31:0] z     [4];
   logic               z_stb [4];
   logic               oack  [4];
   logic               sat   [4];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // 0: passthrough defaults, 1: 3-tap average, 2: one-pole low-pass, 3: overdriven gain
   iir_biquad_lpf u_pass (
      .clk(clk), .rst(rst), .input_a(in_a[0]), .input_a_stb(stb[0]), .input_a_ack(ack[0]),
      .output_z(z[0]), .output_z_stb(z_stb[0]), .output_z_ack(oack[0]), .sat_flag(sat[0]));

   iir_biquad_lpf #(.B0(18'sd16384), .B1(18'sd16384), .B2(18'sd16384), .A1(18'sd0), .A2(18'sd0)) u_avg (
      .clk(clk), .rst(rst), .input_a(in_a[1]), .input_a_stb(stb[1]), .input_a_ack(ack[1]),
      .output_z(z[1]), .output_z_stb(z_stb[1]), .output_z_ack(oack[1]), .sat_flag(sat[1]));

   iir_biquad_lpf #(.B0(18'sd32768), .B1(18'sd0), .B2(18'sd0), .A1(-18'sd32768), .A2(18'sd0)) u_lp (
      .clk(clk), .rst(rst), .input_a(in_a[2]), .input_a_stb(stb[2]), .input_a_ack(ack[2]),
      .output_z(z[2]), .output_z_stb(z_stb[2]), .output_z_ack(oack[2]), .sat_flag(sat[2]));

   iir_biquad_lpf #(.B0(18'sd131071)) u_sat (
      .clk(clk), .rst(rst), .input_a(in_a[3]), .input_a_stb(stb[3]), .input_a_ack(ack[3]),
      .output_z(z[3]), .output_z_stb(z_stb[3]), .output_z_ack(oack[3]), .sat_flag(sat[3]));

   // Returns at #1 after the edge where output_z_stb rose; lat counts edges after the transfer.
   task automatic send(input int d, input logic signed [31:0] x,
                       output logic signed [31:0] y, output int lat);
      int k;
      y   = 'x;
      lat = -1;
      @(negedge clk);
      in_a[d] = x;
      stb[d]  = 1'b1;
      k = 0;
      while (ack[d] !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         tests++; fails++;
         $display("FAIL accept_timeout dut%0d: input_a_ack never rose", d);
         stb[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 stb[d] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (z_stb[d] === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         tests++; fails++;
         $display("FAIL output_timeout dut%0d: output_z_stb never rose", d);
      end
      y = z[d];
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         tests++;
         if (ack[d] !== 1'b0 || z[d] !== 32'sd0 || z_stb[d] !== 1'b0 || sat[d] !== 1'b0) begin
            fails++;
            $display("FAIL reset_state dut%0d: ack=%b z=%0d stb=%b sat=%b, required 0,0,0,0",
                     d, ack[d], z[d], z_stb[d], sat[d]);
         end
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (ack[0] !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ack: got %b, required 1", ack[0]);
      end
   endtask

   task automatic test_passthrough;
      logic signed [31:0] y;
      int lat;
      send(0, 32'sd1234, y, lat);
      tests++;
      if (y !== 32'sd1234) begin fails++; $display("FAIL pass_1234: got %0d, required 1234", y); end
      tests++;
      if (lat !== 6) begin fails++; $display("FAIL pass_latency: got %0d, required 6", lat); end
      send(0, -32'sd77, y, lat);
      tests++;
      if (y !== -32'sd77) begin fails++; $display("FAIL pass_m77: got %0d, required -77", y); end
      tests++;
      if (sat[0] !== 1'b0) begin fails++; $display("FAIL pass_sat: got %b, required 0", sat[0]); end
   endtask

   task automatic test_fir_average;
      logic signed [31:0] xin [4] = '{32'sd100, 32'sd0, 32'sd0, 32'sd0};
      logic signed [31:0] exp [4] = '{32'sd25, 32'sd25, 32'sd25, 32'sd0};
      logic signed [31:0] y;
      int lat;
      for (int i = 0; i < 4; i++) begin
         send(1, xin[i], y, lat);
         tests++;
         if (y !== exp[i]) begin
            fails++;
            $display("FAIL fir_avg[%0d]: got %0d, required %0d", i, y, exp[i]);
         end
      end
   endtask

   task automatic test_feedback_step;
      logic signed [31:0] exp [4] = '{32'sd500, 32'sd750, 32'sd875, 32'sd938};
      logic signed [31:0] y;
      int lat;
      for (int i = 0; i < 4; i++) begin
         send(2, 32'sd1000, y, lat);
         tests++;
         if (y !== exp[i]) begin
            fails++;
            $display("FAIL iir_step[%0d]: got %0d, required %0d", i, y, exp[i]);
         end
      end
   endtask

   task automatic test_saturation;
      logic signed [31:0] y;
      int lat;
      send(3, 32'sh7FFF_FFFF, y, lat);
      tests++;
      if (y !== 32'sh7FFF_FFFF) begin fails++; $display("FAIL sat_pos: got %0d, required 2147483647", y); end
      tests++;
      if (sat[3] !== 1'b1) begin fails++; $display("FAIL sat_flag_set: got %b, required 1", sat[3]); end
      send(3, 32'sh8000_0000, y, lat);
      tests++;
      if (y !== 32'sh8000_0000) begin fails++; $display("FAIL sat_neg: got %0d, required -2147483648", y); end
      tests++;
      if (sat[3] !== 1'b1) begin fails++; $display("FAIL sat_flag_sticky: got %b, required 1", sat[3]); end
   endtask

   task automatic test_output_hold;
      logic signed [31:0] y;
      int lat;
      oack[0] = 1'b0;
      send(0, 32'sd555, y, lat);
      tests++;
      if (y !== 32'sd555) begin fails++; $display("FAIL hold_value: got %0d, required 555", y); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if (z_stb[0] !== 1'b1 || z[0] !== 32'sd555 || ack[0] !== 1'b0) begin
            fails++;
            $display("FAIL hold_cycle%0d: stb=%b z=%0d ack=%b, required 1,555,0", i, z_stb[0], z[0], ack[0]);
         end
      end
      oack[0] = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (z_stb[0] !== 1'b0 || ack[0] !== 1'b1 || z[0] !== 32'sd555) begin
         fails++;
         $display("FAIL hold_release: stb=%b ack=%b z=%0d, required 0,1,555", z_stb[0], ack[0], z[0]);
      end
   endtask

   task automatic test_back_to_back;
      int first, second, seen;
      first = -1; second = -1; seen = 0;
      @(negedge clk);
      in_a[0] = 32'sd42;
      stb[0]  = 1'b1;
      for (int i = 0; i < 40 && seen < 2; i++) begin
         @(posedge clk);
         #1;
         if (z_stb[0] === 1'b1) begin
            if (seen == 0) first = cyc; else second = cyc;
            seen++;
         end
      end
      stb[0] = 1'b0;
      tests++;
      if (seen < 2 || (second - first) !== 8) begin
         fails++;
         $display("FAIL b2b_period: got %0d outputs spaced %0d cycles, required 2 spaced 8", seen, second - first);
      end
      tests++;
      if (z[0] !== 32'sd42) begin fails++; $display("FAIL b2b_value: got %0d, required 42", z[0]); end
      repeat (10) @(posedge clk);
   endtask

   task automatic test_reset_mid_sample;
      logic signed [31:0] y;
      int lat, k, saw;
      send(1, 32'sd100, y, lat);
      tests++;
      if (y !== 32'sd25) begin fails++; $display("FAIL prime_avg: got %0d, required 25", y); end
      @(negedge clk);
      in_a[0] = 32'sd999;
      stb[0]  = 1'b1;
      k = 0;
      while (ack[0] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      @(posedge clk);
      #1 stb[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      saw = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (z_stb[0] === 1'b1) saw = 1;
      end
      tests++;
      if (k >= 20 || saw != 0) begin
         fails++;
         $display("FAIL abort_no_output: accept_wait=%0d saw_stb=%0d, required <20,0", k, saw);
      end
      tests++;
      if (sat[3] !== 1'b0) begin fails++; $display("FAIL abort_sat_clear: got %b, required 0", sat[3]); end
      send(0, 32'sd1234, y, lat);
      tests++;
      if (y !== 32'sd1234) begin fails++; $display("FAIL abort_next: got %0d, required 1234", y); end
      send(1, 32'sd0, y, lat);
      tests++;
      if (y !== 32'sd0) begin fails++; $display("FAIL abort_hist_clear: got %0d, required 0", y); end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         in_a[d] = '0;
         stb[d]  = 1'b0;
         oack[d] = 1'b1;
      end
      test_reset;
      test_passthrough;
      test_fir_average;
      test_feedback_step;
      test_saturation;
      test_output_hold;
      test_back_to_back;
      test_reset_mid_sample;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/iir_biquad_lpf.md
IIR_BIQUAD_LPF -- requirements
Module: iir_biquad_lpf

Interface
REQ-001 SHALL have parameter DW, default 32: input/output sample width, signed two's complement.
REQ-002 SHALL have parameter CW, default 18: coefficient width, signed.
REQ-003 SHALL have parameter FRAC, default 16: coefficient fractional bits.
REQ-004 SHALL have parameters B0, B1, B2, A1, A2, each CW-bit signed, defaults 65536, 0, 0, 0, 0 (passthrough).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port input_a, input, DW bits: sample x[n] from the upstream stimulus file reader.
REQ-008 SHALL have port input_a_stb, input, 1 bit: upstream sample valid.
REQ-009 SHALL have port input_a_ack, output, 1 bit: block ready to accept a sample.
REQ-010 SHALL have port output_z, output, DW bits: filtered sample y[n].
REQ-011 SHALL have port output_z_stb, output, 1 bit: output valid.
REQ-012 SHALL have port output_z_ack, input, 1 bit: downstream accepts output.
REQ-013 SHALL have port sat_flag, output, 1 bit: sticky saturation indicator.

Function
REQ-014 SHALL implement y[n] = (B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2] + 2^(FRAC-1)) >>> FRAC, arithmetic shift (round half toward +inf).
REQ-015 SHALL accumulate in a signed register of at least DW+CW+3 bits with no intermediate overflow.
REQ-016 SHALL saturate the shifted result to [-2^(DW-1), 2^(DW-1)-1] and set sat_flag on any clamp; sat_flag clears only on rst.
REQ-017 SHALL use FSM states IDLE, MAC, ROUND, OUT.
REQ-018 SHALL drive input_a_ack = 1 only in IDLE with rst low; transfer occurs at an edge where input_a_stb and input_a_ack are both 1.
REQ-019 On input transfer (edge E0): SHALL latch x[n], clear the accumulator, and enter MAC.
REQ-020 In MAC: SHALL add exactly one product term per cycle at edges E1..E5, in order B0, B1, B2, A1, A2, using a single multiplier.
REQ-021 At E6 (ROUND): SHALL register the rounded, saturated result into output_z, set output_z_stb=1, shift histories (x[n-2]<=x[n-1], x[n-1]<=x[n], y[n-2]<=y[n-1], y[n-1]<=y[n] saturated), and enter OUT.
REQ-022 In OUT: SHALL hold output_z and output_z_stb stable until an edge with output_z_ack=1, then clear output_z_stb and enter IDLE (input_a_ack=1 the following cycle).
REQ-023 With output_z_ack tied high, SHALL sustain one sample per 8 cycles.
REQ-024 SHALL ignore input_a_stb outside IDLE and output_z_ack outside OUT.
REQ-025 output_z SHALL retain its last value after the output handshake until the next ROUND.

Reset
REQ-026 At any edge with rst=1, SHALL force state=IDLE, output_z=0, output_z_stb=0, sat_flag=0, accumulator=0, all four history registers=0; input_a_ack SHALL be 0 while rst=1.
REQ-027 rst asserted mid-MAC, ROUND or OUT SHALL abort the sample in flight, emit no output, and take priority over any simultaneous handshake.

Verification
REQ-028 Default coefficients, input 1234 then -77 -> output_z 1234 with stb at E6, then -77; sat_flag=0.
REQ-029 B0=B1=B2=16384, A1=A2=0, inputs 100,0,0,0 -> outputs 25,25,25,0.
REQ-030 B0=32768, A1=-32768, others 0, step input 1000 x4 -> outputs 500,750,875,938.
REQ-031 B0=131071, input 2147483647 -> output 2147483647, sat_flag=1; then input -2147483648 -> output -2147483648, sat_flag stays 1.
REQ-032 output_z_ack held low 10 cycles in OUT -> output_z_stb stays 1, output_z stable, input_a_ack stays 0; ack on cycle 11 -> input_a_ack=1 next cycle.
REQ-033 rst pulsed at E3 of a sample -> no output_z_stb, histories cleared; next input 1234 (default coefs) -> output 1234.
